digest_rx: RTL and testbench
============================

// Module: digest_rx
// PURPOSE
//  Receive end of the hash-output byte stream (data/dv/end) from the BLAKE2 data manager.
//  Reassembles the LSB-first byte stream into a W*8-bit digest and holds it until acknowledged.
//  Compares it against an expected value and flags length and overrun errors.
//  Sits between the hash core's output manager and the checker/host register interface.
// PARAMETERS
//  W       32  digest length in bytes; digest width W*8 bits, matching the sender's W
//  CMP_EN  1   1: compare against expected; 0: match output tied 0
// PORTS
//  clk           in   1     clock; all state on rising edge
//  rst_n         in   1     asynchronous active-low reset
//  data_in       in   8     stream byte, valid when dv_in=1
//  dv_in         in   1     byte strobe; one byte per cycle, no backpressure
//  data_end_in   in   1     marks the final byte; meaningful only with dv_in=1
//  expected      in   W*8   reference digest; sampled in CMP state
//  digest_ack    in   1     consumer releases the held digest
//  digest_out    out  W*8   assembled digest; byte k at bits [8k+:8]
//  digest_valid  out  1     digest held and results valid
//  match         out  1     digest_out==expected; valid with digest_valid
//  len_err       out  1     final byte index != W-1
//  drop_err      out  1     sticky: bytes arrived while holding and were discarded
//  busy          out  1     frame in progress (state RECV or CMP)
//  byte_cnt      out  $clog2(W)+1  bytes captured in the current or held frame
// BEHAVIOUR
//  Reset: all outputs 0, digest_out=0, state IDLE; async assert, sync deassert assumed upstream.
//  State IDLE:
//   - dv_in: clear digest, store byte at [7:0], byte_cnt=1.
//   - If data_end_in is also set, go to CMP; otherwise go to RECV.
//  State RECV:
//   - dv_in: store at [8*byte_cnt+:8], byte_cnt++.
//   - If data_end_in, or byte_cnt+1==W, go to CMP.
//   - No dv_in: hold; no timeout.
//  State CMP (exactly 1 cycle, regardless of dv_in):
//   - Register match = CMP_EN & (digest==expected).
//   - Register len_err = (byte_cnt != W) | (W reached without data_end_in).
//   - Set digest_valid=1; go to HOLD.
//   - A dv_in here is dropped and sets drop_err.
//  State HOLD:
//   - Outputs frozen.
//   - dv_in without digest_ack: byte dropped, drop_err=1 (sticky).
//   - digest_ack: clear digest_valid, match, len_err, drop_err next cycle.
//   - If dv_in is also set on the ack cycle, that byte starts a new frame exactly as in IDLE.
//   - Otherwise return to IDLE.
//  Other rules:
//   - digest_ack outside HOLD is ignored. data_end_in without dv_in is ignored.
//   - Latency: final byte on cycle N; digest_valid/match/len_err high from N+2.
//   - byte_cnt never exceeds W; the byte arriving at W is treated as the end.
//   - Reset mid-frame discards the partial digest; a following stream starts at byte 0.
// TESTING
//  1. W=32: 32 bytes 0x00..0x1F, end on last; expected=0x1F1E..0100
//     -> valid at N+2, match=1, len_err=0, digest_out[7:0]=0x00.
//  2. Same stream, expected bit 255 flipped -> match=0, len_err=0, digest_valid=1.
//  3. data_end_in on byte 10 (0-based) -> CMP after 11 bytes, byte_cnt=11, len_err=1, upper bytes 0.
//  4. 35 bytes, no data_end_in -> capture stops at 32, len_err=1;
//     3 extra bytes dropped, drop_err=1; ack clears all.
//  5. In HOLD, ack together with dv_in=0xAA -> new frame, digest_out[7:0]=0xAA,
//     byte_cnt=1, busy=1, digest_valid=0.
//  6. rst_n low after 7 bytes, then a full 32-byte stream -> clean match, no len_err/drop_err.

Source files
------------

// File: rtl/digest_rx_if.sv
// Byte stream from the hash output manager: one byte per strobe, LSB-first,
// final byte flagged. The stream has no backpressure.
interface digest_rx_if;
    logic [7:0] data_in;
    logic       dv_in;
    logic       data_end_in;

    modport master (output data_in, dv_in, data_end_in);
    modport slave  (input  data_in, dv_in, data_end_in);
endinterface

// File: rtl/digest_rx.sv
// Reassembles an LSB-first byte stream into a W-byte digest, compares it with an
// expected value and holds the result until the consumer acknowledges it.
module digest_rx #(
    parameter  int W      = 32,
    parameter  bit CMP_EN = 1'b1,
    localparam int CW     = $clog2(W) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    digest_rx_if.slave      rx,
    input  logic [W*8-1:0]  expected,
    input  logic            digest_ack,
    output logic [W*8-1:0]  digest_out,
    output logic            digest_valid,
    output logic            match,
    output logic            len_err,
    output logic            drop_err,
    output logic            busy,
    output logic [CW-1:0]   byte_cnt
);
    typedef enum logic [1:0] {IDLE, RECV, CMP, HOLD} state_t;

    state_t     state_reg;
    logic       no_end_reg;
    logic [7:0] lane_reg [W];
    logic       start_frame;
    logic       recv_wr;
    logic       last_byte;

    // An ack arriving together with a byte releases the old digest and opens a new frame.
    assign start_frame = rx.dv_in && ((state_reg == IDLE) || (state_reg == HOLD && digest_ack));
    assign recv_wr     = rx.dv_in && (state_reg == RECV);
    assign last_byte   = (byte_cnt + CW'(1)) == CW'(W);

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_lane
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg[gi] <= 8'h00;
                end else if (start_frame) begin
                    lane_reg[gi] <= (gi == 0) ? rx.data_in : 8'h00;
                end else if (recv_wr && byte_cnt == CW'(gi)) begin
                    lane_reg[gi] <= rx.data_in;
                end
            end
            assign digest_out[8*gi +: 8] = lane_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            no_end_reg   <= 1'b0;
            byte_cnt     <= '0;
            busy         <= 1'b0;
            digest_valid <= 1'b0;
            match        <= 1'b0;
            len_err      <= 1'b0;
            drop_err     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_frame) begin
                        state_reg  <= (rx.data_end_in || W == 1) ? CMP : RECV;
                        byte_cnt   <= CW'(1);
                        no_end_reg <= !rx.data_end_in;
                        busy       <= 1'b1;
                    end
                end
                RECV: begin
                    if (rx.dv_in) begin
                        byte_cnt   <= byte_cnt + CW'(1);
                        no_end_reg <= !rx.data_end_in;
                        if (rx.data_end_in || last_byte) begin
                            state_reg <= CMP;
                        end
                    end
                end
                CMP: begin
                    // no_end_reg flags a frame that filled W bytes without seeing its end marker.
                    match        <= CMP_EN && (digest_out == expected);
                    len_err      <= (byte_cnt != CW'(W)) || no_end_reg;
                    digest_valid <= 1'b1;
                    busy         <= 1'b0;
                    state_reg    <= HOLD;
                    if (rx.dv_in) begin
                        drop_err <= 1'b1;
                    end
                end
                HOLD: begin
                    if (digest_ack) begin
                        digest_valid <= 1'b0;
                        match        <= 1'b0;
                        len_err      <= 1'b0;
                        drop_err     <= 1'b0;
                        if (start_frame) begin
                            state_reg  <= (rx.data_end_in || W == 1) ? CMP : RECV;
                            byte_cnt   <= CW'(1);
                            no_end_reg <= !rx.data_end_in;
                            busy       <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (rx.dv_in) begin
                        drop_err <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_digest_rx.sv
// Randomized scoreboard bench for digest_rx: the stimulus side predicts each frame's
// result from the byte list, and a monitor checks it when digest_valid rises.
module tb_digest_rx;
    localparam int W  = 32;
    localparam int CW = $clog2(W) + 1;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [W*8-1:0] dig;
        logic           m;
        logic           le;
        int             cnt;
        int             cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    digest_rx_if rx();
    logic [W*8-1:0] expected;
    logic [W*8-1:0] digest_out;
    logic           digest_ack;
    logic           digest_valid, match, len_err, drop_err, busy;
    logic [CW-1:0]  byte_cnt;

    digest_rx #(.W(W), .CMP_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .expected(expected), .digest_ack(digest_ack),
        .digest_out(digest_out), .digest_valid(digest_valid), .match(match),
        .len_err(len_err), .drop_err(drop_err), .busy(busy), .byte_cnt(byte_cnt)
    );

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W*8-1:0] act, input logic [W*8-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each newly presented digest with the oldest prediction.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            if (digest_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: digest_valid rose with no frame pending");
                end else begin
                    mon_e = sb.pop_front();
                    check("digest", digest_out, mon_e.dig);
                    check("match", W*8'(match), W*8'(mon_e.m));
                    check("len_err", W*8'(len_err), W*8'(mon_e.le));
                    check("byte_cnt", W*8'(byte_cnt), W*8'(mon_e.cnt));
                    check("latency_cycle", W*8'(cyc), W*8'(mon_e.cyc));
                    $display("[TB] frame cyc=%0d cnt=%0d match=%0b len_err=%0b digest[31:0]=%08h",
                             cyc, byte_cnt, match, len_err, digest_out[31:0]);
                end
            end
            prev_valid <= digest_valid;
        end
    end

    // Drives one stream; predicts the captured digest from the stream rules and queues it.
    task automatic send_frame(input bq_t q, input int end_pos, input bit with_ack,
                              input int max_gap, input int flip_bit, output bit exp_drop);
        int             cap;
        logic [W*8-1:0] dig;
        exp_t           e;
        cap = (end_pos >= 0 && end_pos < W) ? end_pos + 1 : W;
        dig = '0;
        for (int i = 0; i < cap && i < q.size(); i++) dig |= (W*8)'(q[i]) << (8 * i);
        exp_drop = q.size() > cap;
        expected = (flip_bit >= 0) ? (dig ^ ((W*8)'(1) << flip_bit)) : dig;
        for (int i = 0; i < q.size(); i++) begin
            if (i > 0 && max_gap > 0) begin
                repeat ($urandom_range(max_gap)) begin
                    @(negedge clk);
                    rx.dv_in = 1'b0;
                    rx.data_end_in = 1'($urandom_range(1));
                    digest_ack = 1'b0;
                end
            end
            @(negedge clk);
            if (i == 1 && with_ack) begin
                check("ack_new_byte0", W*8'(digest_out[7:0]), W*8'(q[0]));
                check("ack_new_cnt", W*8'(byte_cnt), W*8'(1));
                check("ack_new_busy", W*8'(busy), W*8'(1));
                check("ack_new_valid", W*8'(digest_valid), W*8'(0));
            end
            rx.data_in = q[i];
            rx.dv_in = 1'b1;
            rx.data_end_in = (i == end_pos);
            digest_ack = (i == 0) && with_ack;
            if (i == cap - 1) begin
                e.dig = dig;
                e.m   = (expected == dig);
                e.le  = (end_pos != W - 1);
                e.cnt = cap;
                e.cyc = cyc + 2;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        rx.dv_in = 1'b0;
        rx.data_end_in = 1'b0;
        digest_ack = 1'b0;
    endtask

    task automatic wait_hold(input bit exp_drop);
        for (int k = 0; k < 10 && !digest_valid; k++) @(negedge clk);
        check("valid_wait", W*8'(digest_valid), W*8'(1));
        check("drop_err", W*8'(drop_err), W*8'(exp_drop));
    endtask

    task automatic ack_and_check();
        @(negedge clk);
        digest_ack = 1'b1;
        @(negedge clk);
        digest_ack = 1'b0;
        check("ack_clear", W*8'({digest_valid, match, len_err, drop_err, busy}), W*8'(0));
    endtask

    function automatic bq_t ramp(input int n, input int base);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'(base + i));
        return q;
    endfunction

    initial begin
        bit   drop;
        bq_t  q;
        int   n, ep, mode;
        rx.data_in = 8'h00;
        rx.dv_in = 1'b0;
        rx.data_end_in = 1'b0;
        digest_ack = 1'b0;
        expected = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_digest", digest_out, '0);
        check("reset_flags", W*8'({digest_valid, match, len_err, drop_err, busy}), W*8'(0));
        check("reset_cnt", W*8'(byte_cnt), W*8'(0));

        // full ramp frame, then the same with bit 255 of expected flipped
        send_frame(ramp(32, 0), 31, 1'b0, 0, -1, drop);
        wait_hold(drop);
        ack_and_check();
        send_frame(ramp(32, 0), 31, 1'b0, 0, 255, drop);
        wait_hold(drop);
        ack_and_check();
        // early end on byte 10
        send_frame(ramp(11, 8'h40), 10, 1'b0, 0, -1, drop);
        wait_hold(drop);
        ack_and_check();
        // 35 bytes without end marker: 3 overflow bytes dropped
        send_frame(ramp(35, 8'h80), -1, 1'b0, 0, -1, drop);
        wait_hold(drop);
        ack_and_check();
        // ack in HOLD together with a new first byte 0xAA
        send_frame(ramp(32, 8'h10), 31, 1'b0, 0, -1, drop);
        wait_hold(drop);
        q = ramp(32, 8'hC0);
        q[0] = 8'hAA;
        send_frame(q, 31, 1'b1, 0, -1, drop);
        wait_hold(drop);
        ack_and_check();
        // reset mid-frame, then a clean full frame
        send_frame(ramp(7, 8'h55), -1, 1'b0, 0, -1, drop);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_state", W*8'({byte_cnt, busy, digest_valid}), W*8'(0));
        check("midreset_digest", digest_out, '0);
        send_frame(ramp(32, 8'h20), 31, 1'b0, 0, -1, drop);
        wait_hold(drop);
        ack_and_check();

        for (int t = 0; t < 24; t++) begin
            q = {};
            mode = $urandom_range(2);
            if (mode == 0) begin
                n = $urandom_range(1, 40);
                ep = $urandom_range(0, n - 1);
            end else if (mode == 1) begin
                n = $urandom_range(W, W + 6);
                ep = -1;
            end else begin
                n = $urandom_range(W, W + 3);
                ep = W - 1;
            end
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            send_frame(q, ep, 1'b0, 2, ($urandom_range(1) != 0) ? -1 : int'($urandom_range(W*8-1)), drop);
            wait_hold(drop);
            ack_and_check();
        end

        repeat (3) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d predictions left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
